mux8_rr_sched: RTL
==================

MUX8_RR_SCHED -- requirements
Module: mux8_rr_sched

Interface
REQ-001 Parameter BURST, default 4, maximum consecutive cycles one requester holds the mux; legal range 1..8.
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  8  per-lane request; bit i = lane i wants the shared output.
REQ-005 data_in  input  8  per-lane data bit; bit i = lane i data.
REQ-006 gnt  output  8  registered one-hot grant; all-zero when idle.
REQ-007 sel  output  3  registered 8:1 mux select; index of the granted lane.
REQ-008 busy  output  1  registered; 1 while any lane is granted.
REQ-009 data_out  output  1  registered mux output, data_in[sel] delayed one cycle.
REQ-010 data_valid  output  1  registered; busy delayed one cycle, qualifies data_out.

Function
REQ-011 FSM states: IDLE (no grant), GRANT (one lane holds sel); busy SHALL be 1 exactly in GRANT.
REQ-012 IDLE -> GRANT on the first edge where req != 0; IDLE self-loops while req == 0.
REQ-013 Arbitration: next lane = first i with req[i]=1, searching last+1, last+2, ... wrapping mod 8, last lane itself checked last.
REQ-014 "last" SHALL be the most recently granted lane; after reset last = 7, so first search starts at lane 0.
REQ-015 On each new grant: gnt = one-hot(i), sel = i, last = i, burst counter = 1; all update on the same edge.
REQ-016 In GRANT, burst counter SHALL increment by 1 per cycle while the grant is held; width 4 bits, never exceeds BURST.
REQ-017 Release condition, sampled each edge in GRANT: req[sel] = 0, or burst counter = BURST.
REQ-018 On release with another arbitration winner available, the new grant SHALL take effect on that same edge (no idle bubble).
REQ-019 On release with req == 0, go to IDLE; gnt = 0, busy = 0, sel holds its last value.
REQ-020 If the releasing lane is the only requester when its burst expires, it SHALL be re-granted immediately, counter = 1.
REQ-021 A lane dropping req mid-burst SHALL lose the grant at the edge that samples req[sel] = 0, regardless of remaining burst.
REQ-022 Requests on other lanes SHALL NOT pre-empt an active grant before its release condition.
REQ-023 data_out SHALL equal data_in[sel] sampled on the previous edge when busy was 1, else 0; data_valid = previous-cycle busy.
REQ-024 gnt SHALL never have more than one bit set; gnt[sel] = 1 whenever busy = 1.
REQ-025 BURST = 1 degenerates to strict per-cycle round-robin among active requesters.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, gnt = 0, sel = 0, busy = 0, data_out = 0, data_valid = 0, counter = 0, last = 7.
REQ-027 Reset asserted mid-burst SHALL abort the grant asynchronously; after release, arbitration restarts from lane 0.
REQ-028 First arbitration SHALL occur on the first rising edge after rst_n deasserts.

Verification
REQ-029 Reset, req = 8'h00 for 5 cycles -> gnt = 0, busy = 0, data_valid = 0 throughout.
REQ-030 BURST=4, req = 8'b0000_0100 held, data_in[2] toggling -> sel = 2, gnt = 8'h04 continuously, regrant every 4 cycles, data_out follows data_in[2] one cycle late.
REQ-031 BURST=4, req = 8'hFF held -> grants 0,1,2,...,7,0 each lasting exactly 4 cycles, no idle cycles between.
REQ-032 Lane 5 granted, req[5] drops after 2 cycles, req[1] high -> gnt moves to 8'h02 on the edge sampling req[5] = 0.
REQ-033 last = 6, req = 8'b0100_0001 -> next grant lane 0 (wrap), then lane 6 after lane 0's burst.
REQ-034 rst_n pulsed low mid-burst on lane 3 -> outputs zero immediately; with req = 8'h08 after release, lane 3 regranted, counter restarts at 1.

Source files
------------

// File: rtl/mux8_rr_sched.sv
// Round-robin arbiter over eight request lanes driving a registered 8:1 data-bit mux.
// A granted lane holds the mux for at most BURST cycles before the grant rotates.
module mux8_rr_sched #(
   parameter int unsigned BURST = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic [7:0] data_in,
   output logic [7:0] gnt,
   output logic [2:0] sel,
   output logic       busy,
   output logic       data_out,
   output logic       data_valid
);

   localparam logic [3:0] BurstMax = 4'(BURST);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e     state_q;
   logic [7:0] gnt_q;
   logic [2:0] sel_q;
   logic [2:0] last_q;
   logic [3:0] cnt_q;
   logic       busy_q;
   logic       data_out_q;
   logic       data_valid_q;

   logic       win_found;
   logic [2:0] win_idx;
   logic       release_grant;

   // Search last+1 .. last+8; k = 8 wraps back onto the last lane, so it is checked last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = last_q;
      for (int k = 1; k <= 8; k++) begin
         if (!win_found && req[3'(last_q + 3'(k))]) begin
            win_found = 1'b1;
            win_idx   = 3'(last_q + 3'(k));
         end
      end
   end

   assign release_grant = !req[sel_q] || (cnt_q == BurstMax);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         gnt_q        <= 8'h00;
         sel_q        <= 3'd0;
         last_q       <= 3'd7;
         cnt_q        <= 4'd0;
         busy_q       <= 1'b0;
         data_out_q   <= 1'b0;
         data_valid_q <= 1'b0;
      end else begin
         data_out_q   <= busy_q & data_in[sel_q];
         data_valid_q <= busy_q;
         case (state_q)
            StIdle: begin
               if (win_found) begin
                  state_q <= StGrant;
                  gnt_q   <= 8'h01 << win_idx;
                  sel_q   <= win_idx;
                  last_q  <= win_idx;
                  cnt_q   <= 4'd1;
                  busy_q  <= 1'b1;
               end
            end
            StGrant: begin
               if (release_grant) begin
                  if (win_found) begin
                     // Hand-over (or re-grant of a sole requester) on the releasing edge.
                     gnt_q  <= 8'h01 << win_idx;
                     sel_q  <= win_idx;
                     last_q <= win_idx;
                     cnt_q  <= 4'd1;
                  end else begin
                     state_q <= StIdle;
                     gnt_q   <= 8'h00;
                     cnt_q   <= 4'd0;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: begin
               state_q <= StIdle;
               gnt_q   <= 8'h00;
               cnt_q   <= 4'd0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt        = gnt_q;
   assign sel        = sel_q;
   assign busy       = busy_q;
   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;

endmodule
